// File: rtl/esop_seq_eval.sv
// Sequential ESOP evaluator: cube list held in a register file, LANES cubes per cycle
// are ANDed against the latched input and XORed into per-output parity accumulators.
module esop_seq_eval #(
  parameter int NUM_IN    = 10,
  parameter int NUM_OUT   = 1,
  parameter int MAX_CUBES = 128,
  parameter int LANES     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [$clog2(MAX_CUBES)-1:0]   cfg_addr,
  input  logic [2*NUM_IN-1:0]            cfg_cube,
  input  logic [NUM_OUT-1:0]             cfg_omask,
  input  logic                           cfg_cnt_we,
  input  logic [$clog2(MAX_CUBES+1)-1:0] cfg_cnt,
  output logic                           cfg_ready,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_IN-1:0]              in_x,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_OUT-1:0]             out_f,
  output logic                           busy
);

  localparam int AW = $clog2(MAX_CUBES);
  localparam int CW = $clog2(MAX_CUBES+1);
  localparam int IW = $clog2(MAX_CUBES+LANES);
  localparam int SW = IW + 1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t              state, state_nxt;
  logic [2*NUM_IN-1:0] cube_mem  [MAX_CUBES];
  logic [NUM_OUT-1:0]  omask_mem [MAX_CUBES];
  logic [CW-1:0]       cnt, cnt_new, cnt_eff;
  logic [IW-1:0]       idx;
  logic [NUM_IN-1:0]   x_q;
  logic [NUM_OUT-1:0]  acc, acc_nxt, lane_xor;
  logic [SW-1:0]       lane_idx;
  logic                last_step;

  function automatic logic cube_hit(input logic [2*NUM_IN-1:0] c, input logic [NUM_IN-1:0] x);
    logic h;
    h = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      case (c[2*i +: 2])
        2'b01:   if (!x[i]) h = 1'b0;
        2'b10:   if (x[i])  h = 1'b0;
        2'b11:   h = 1'b0;
        default: ;
      endcase
    end
    return h;
  endfunction

  assign cnt_new = (cfg_cnt > CW'(MAX_CUBES)) ? CW'(MAX_CUBES) : cfg_cnt;
  // A count written in the same cycle as an accepted input governs that evaluation.
  assign cnt_eff = cfg_cnt_we ? cnt_new : cnt;

  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (state == IDLE && cfg_we && (int'(cfg_addr) < MAX_CUBES)) begin
      cube_mem[cfg_addr]  <= cfg_cube;
      omask_mem[cfg_addr] <= cfg_omask;
    end
  end

  always_comb begin
    lane_xor = '0;
    lane_idx = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx = SW'(idx) + SW'(l);
      if (lane_idx < SW'(cnt) && cube_hit(cube_mem[lane_idx[AW-1:0]], x_q))
        lane_xor = lane_xor ^ omask_mem[lane_idx[AW-1:0]];
    end
  end

  assign acc_nxt   = acc ^ lane_xor;
  assign last_step = (SW'(idx) + SW'(LANES)) >= SW'(cnt);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (cnt_eff != '0) ? EVAL : DONE;
      EVAL:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      acc       <= '0;
      x_q       <= '0;
      out_f     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (cfg_cnt_we) cnt <= cnt_new;
          if (in_valid) begin
            x_q <= in_x;
            acc <= '0;
            idx <= '0;
            if (cnt_eff == '0) out_f <= '0;
          end
        end
        EVAL: begin
          acc <= acc_nxt;
          idx <= idx + IW'(LANES);
          if (last_step) out_f <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/esop_seq_eval.md
Name: esop_seq_eval

Overview:
- Programmable, sequential evaluator for multi-output ESOP (XOR-of-products) functions.
- Cube list is loaded at run time into an internal cube memory.
- Each accepted input vector is evaluated by streaming LANES cubes per cycle through AND/XOR logic into per-output parity accumulators.
- Sits beside the fixed combinational ESOP benchmark netlists as a reconfigurable golden model and hardware checker for synthesized ESOP covers.

Parameters:
NUM_IN, 10, number of input variables x[NUM_IN-1:0]
NUM_OUT, 1, number of outputs sharing the cube list
MAX_CUBES, 128, cube memory depth (≥1)
LANES, 1, cubes evaluated per EVAL cycle (1..MAX_CUBES)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
cfg_we  in  1  write cube at cfg_addr (accepted only when cfg_ready)
cfg_addr  in  $clog2(MAX_CUBES)  cube index
cfg_cube  in  2*NUM_IN  literal code, bits [2i+1:2i] for x[i]
cfg_omask  in  NUM_OUT  outputs this cube contributes to
cfg_cnt_we  in  1  load active cube count (accepted only when cfg_ready)
cfg_cnt  in  $clog2(MAX_CUBES+1)  active cube count N, values >MAX_CUBES saturate to MAX_CUBES
cfg_ready  out  1  high only in IDLE
in_valid  in  1  input vector valid
in_ready  out  1  high only in IDLE
in_x  in  NUM_IN  input vector
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_f  out  NUM_OUT  function values
busy  out  1  state != IDLE

Behaviour:
- Literal code per variable: 00 don't-care; 01 x[i]; 10 ~x[i]; 11 contradiction, so the cube is constant 0.
- Cube value is the AND over all variables.
- Term contributes to out_f[j] iff cube value is 1 and omask[j] is 1.
- Reset: state=IDLE, out_valid=0, out_f=0, accumulators=0, cube index=0, N=0. Cube memory is not cleared; entries are don't-care until written.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - in_ready=cfg_ready=1.
  - on in_valid: latch in_x, clear acc, idx=0.
  - next state is EVAL if N>0, else DONE.
  - cfg writes take effect at the clock edge.
  - If cfg and in_valid coincide, the cfg write applies first; the new cube or count is used by that evaluation.
- EVAL:
  - each cycle processes cubes idx..idx+LANES-1, masking lanes with index ≥N.
  - acc ^= XOR of lane contributions; idx += LANES.
  - moves to DONE when idx+LANES ≥ N.
  - cfg_we and cfg_cnt_we are ignored (cfg_ready=0).
- DONE:
  - out_valid=1, out_f=acc, held stable until out_ready.
  - on out_valid&&out_ready → IDLE.
  - a new input is not accepted in the same cycle.
- Latency: handshake at cycle T gives out_valid first high at T+1+ceil(N/LANES); N=0 gives T+1 with out_f=0.
- Throughput: one evaluation per ceil(N/LANES)+2 cycles when out_ready is held high.
- Reset mid-EVAL or mid-DONE aborts: out_valid drops next cycle and the pending result is discarded. Cube memory is retained; N returns to 0.
- Cube memory: register array, asynchronous read, single write port.
- idx width is $clog2(MAX_CUBES+LANES); no wrap occurs since N≤MAX_CUBES.
- All outputs are registered except cfg_ready, in_ready and busy, which decode directly from the state register.

Test Plan:
- NUM_IN=10, LANES=1.
  - Load cube0=x7 (code 01 at bit7), cube1=x1, cube2=~x0, omask=1, N=3.
  - Apply x=10'b0010000000 → out_f=0, out_valid at T+4.
  - Apply x=10'b0010000010 → out_f=1.
- N=0, any x → out_f=0, out_valid at T+1.
- Contradiction code: cube0 has 11 on x3, N=1, x=all-ones → out_f=0.
  - Rewrite cube0 as all-don't-care → out_f=1.
- LANES=4, MAX_CUBES=8, N=7, all cubes don't-care, omask=1 → out_f=1 (odd parity), latency T+3.
  - Repeat with N=8 → out_f=0.
- NUM_OUT=2: cube0 omask=01 x0, cube1 omask=10 x1, cube2 omask=11 x2.
  - x=3'b101 → out_f=2'b10.
  - Hold out_ready=0 for 5 cycles → out_f stable, in_ready=0.
  - Attempt cfg_we during EVAL → write ignored; verify the next evaluation result is unchanged.
- Assert rst during EVAL with N=100 → out_valid=0 next cycle, in_ready=1.
  - Previously loaded cubes remain intact after reloading N=100 → same result as before reset.
